// File: rtl/multicycle_pkg.sv
// Shared definitions for the multicycle RISC-V core: opcodes, funct codes,
// FSM state encoding, ALU operations and the ALU-op decode helper.
package multicycle_pkg;

    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;
    localparam logic [2:0] F3_WORD = 3'b010;
    localparam logic [2:0] F3_BEQ  = 3'b000;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_SUB  = 7'b0100000;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADDR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXEC,
        S_ALUWB,
        S_BRANCH,
        S_HALT
    } state_e;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_SLT
    } alu_op_e;

    typedef struct packed {
        logic    legal;
        alu_op_e op;
    } alu_dec_t;

    // Map funct3/funct7 to an ALU op; immediate forms ignore funct7 and have no sub.
    function automatic alu_dec_t decode_alu(input logic [2:0] f3,
                                            input logic [6:0] f7,
                                            input logic       is_imm);
        alu_dec_t d;
        d.legal = 1'b0;
        d.op    = ALU_ADD;
        if (is_imm || f7 == F7_BASE) begin
            d.legal = 1'b1;
            case (f3)
                F3_ADD:  d.op = ALU_ADD;
                F3_SLT:  d.op = ALU_SLT;
                F3_OR:   d.op = ALU_OR;
                F3_AND:  d.op = ALU_AND;
                default: d.legal = 1'b0;
            endcase
        end else if (f7 == F7_SUB && f3 == F3_ADD) begin
            d.legal = 1'b1;
            d.op    = ALU_SUB;
        end
        return d;
    endfunction

endpackage

// File: rtl/mc_alu.sv
// Combinational ALU for the multicycle core: add/sub/and/or/signed slt plus a
// zero flag used by the branch compare.
module mc_alu
    import multicycle_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  alu_op_e           op_i,
    input  logic [XLEN-1:0]   a_i,
    input  logic [XLEN-1:0]   b_i,
    output logic [XLEN-1:0]   y_o,
    output logic              zero_o
);

    // Select the result for the requested operation.
    always_comb begin
        y_o = '0;
        case (op_i)
            ALU_ADD: y_o = a_i + b_i;
            ALU_SUB: y_o = a_i - b_i;
            ALU_AND: y_o = a_i & b_i;
            ALU_OR:  y_o = a_i | b_i;
            ALU_SLT: y_o = {{(XLEN-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
            default: y_o = '0;
        endcase
    end

    assign zero_o = (y_o == '0);

endmodule

// File: rtl/multicycle_core.sv
// Multicycle RV32 subset core (lw, sw, add/sub/and/or/slt, beq) with inline
// register file, unified word memory and control FSM.
// Optional feature macro: MULTICYCLE_ITYPE_EN enables addi/andi/ori/slti.
//
// state    | meaning
// FETCH    | IR <- mem[PC], OLDPC <- PC, PC <- PC+4
// DECODE   | read rs1/rs2, precompute branch target, dispatch
// MEMADDR  | effective address A + I/S-immediate
// MEMREAD  | MDR <- mem[ALUOut]
// MEMWB    | rd <- MDR, retire
// MEMWRITE | mem[ALUOut] <- B, retire
// EXEC     | ALUOut <- A op B (or A op imm)
// ALUWB    | rd <- ALUOut, retire
// BRANCH   | PC <- target if A == B, retire
// HALT     | illegal instruction seen; frozen until reset
module multicycle_core
    import multicycle_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int MEM_WORDS = 1024,
    parameter int NUM_REGS  = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         load_we,
    input  logic [$clog2(MEM_WORDS)-1:0] load_addr,
    input  logic [XLEN-1:0]              load_data,
    input  logic [4:0]                   dbg_raddr,
    output logic [XLEN-1:0]              dbg_rdata,
    output logic [XLEN-1:0]              pc,
    output logic                         retire,
    output logic                         halted
);

    localparam int AW = $clog2(MEM_WORDS);
    localparam int RW = $clog2(NUM_REGS);
`ifdef MULTICYCLE_ITYPE_EN
    localparam bit ITYPE_EN = 1'b1;
`else
    localparam bit ITYPE_EN = 1'b0;
`endif

    logic [XLEN-1:0] mem_q  [MEM_WORDS];
    logic [XLEN-1:0] regs_q [NUM_REGS];

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d, oldpc_q, oldpc_d, a_q, a_d, b_q, b_d;
    logic [XLEN-1:0] aluout_q, aluout_d, mdr_q, mdr_d;
    logic [31:0]     ir_q, ir_d;

    logic [6:0] opcode, f7;
    logic [4:0] rd, rs1, rs2;
    logic [2:0] f3;
    logic [XLEN-1:0] imm_i, imm_s, imm_b;
    alu_dec_t   dec;

    logic [AW-1:0]   mem_addr;
    logic [XLEN-1:0] mem_rdata, rf_wdata, alu_a, alu_b, alu_y;
    logic            mem_we, rf_we, retire_c, alu_zero;
    alu_op_e         alu_op;

    assign opcode = ir_q[6:0];
    assign rd     = ir_q[11:7];
    assign f3     = ir_q[14:12];
    assign rs1    = ir_q[19:15];
    assign rs2    = ir_q[24:20];
    assign f7     = ir_q[31:25];
    assign imm_i  = {{(XLEN-12){ir_q[31]}}, ir_q[31:20]};
    assign imm_s  = {{(XLEN-12){ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
    assign imm_b  = {{(XLEN-13){ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
    assign dec    = decode_alu(f3, f7, opcode == OP_ITYPE);

    // x0 and indices beyond NUM_REGS read as zero.
    function automatic logic [XLEN-1:0] rf_read(input logic [4:0] idx);
        if (idx == 5'd0 || int'(idx) >= NUM_REGS) return '0;
        return regs_q[idx[RW-1:0]];
    endfunction

    assign mem_addr  = (state_q == S_FETCH) ? pc_q[2 +: AW] : aluout_q[2 +: AW];
    assign mem_rdata = mem_q[mem_addr];
    assign dbg_rdata = rf_read(dbg_raddr);
    assign pc        = pc_q;
    assign retire    = retire_c;
    assign halted    = (state_q == S_HALT);

    mc_alu #(.XLEN(XLEN)) u_alu (
        .op_i   (alu_op),
        .a_i    (alu_a),
        .b_i    (alu_b),
        .y_o    (alu_y),
        .zero_o (alu_zero)
    );

    // Next-state, datapath updates and write strobes for the current state.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        oldpc_d  = oldpc_q;
        a_d      = a_q;
        b_d      = b_q;
        aluout_d = aluout_q;
        mdr_d    = mdr_q;
        alu_op   = ALU_ADD;
        alu_a    = oldpc_q;
        alu_b    = imm_b;
        rf_we    = 1'b0;
        rf_wdata = aluout_q;
        mem_we   = 1'b0;
        retire_c = 1'b0;
        case (state_q)
            S_FETCH: begin
                ir_d    = mem_rdata[31:0];
                oldpc_d = pc_q;
                pc_d    = pc_q + XLEN'(4);
                state_d = S_DECODE;
            end
            S_DECODE: begin
                a_d      = rf_read(rs1);
                b_d      = rf_read(rs2);
                aluout_d = alu_y;
                case (opcode)
                    OP_LW, OP_SW: state_d = (f3 == F3_WORD) ? S_MEMADDR : S_HALT;
                    OP_RTYPE:     state_d = dec.legal ? S_EXEC : S_HALT;
                    OP_ITYPE:     state_d = (ITYPE_EN && dec.legal) ? S_EXEC : S_HALT;
                    OP_BEQ:       state_d = (f3 == F3_BEQ) ? S_BRANCH : S_HALT;
                    default:      state_d = S_HALT;
                endcase
            end
            S_MEMADDR: begin
                alu_a    = a_q;
                alu_b    = (opcode == OP_SW) ? imm_s : imm_i;
                aluout_d = alu_y;
                state_d  = (opcode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                mdr_d   = mem_rdata;
                state_d = S_MEMWB;
            end
            S_MEMWB: begin
                rf_we    = 1'b1;
                rf_wdata = mdr_q;
                retire_c = 1'b1;
                state_d  = S_FETCH;
            end
            S_MEMWRITE: begin
                mem_we   = 1'b1;
                retire_c = 1'b1;
                state_d  = S_FETCH;
            end
            S_EXEC: begin
                alu_op   = dec.op;
                alu_a    = a_q;
                alu_b    = (ITYPE_EN && opcode == OP_ITYPE) ? imm_i : b_q;
                aluout_d = alu_y;
                state_d  = S_ALUWB;
            end
            S_ALUWB: begin
                rf_we    = 1'b1;
                retire_c = 1'b1;
                state_d  = S_FETCH;
            end
            S_BRANCH: begin
                alu_op   = ALU_SUB;
                alu_a    = a_q;
                alu_b    = b_q;
                if (alu_zero) pc_d = aluout_q;
                retire_c = 1'b1;
                state_d  = S_FETCH;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_FETCH;
        endcase
        // A reset cycle must not commit the instruction it interrupts.
        if (rst) begin
            rf_we    = 1'b0;
            mem_we   = 1'b0;
            retire_c = 1'b0;
        end
    end

    // FSM state and datapath registers; cleared by synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_FETCH;
            pc_q     <= '0;
            ir_q     <= '0;
            oldpc_q  <= '0;
            a_q      <= '0;
            b_q      <= '0;
            aluout_q <= '0;
            mdr_q    <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            oldpc_q  <= oldpc_d;
            a_q      <= a_d;
            b_q      <= b_d;
            aluout_q <= aluout_d;
            mdr_q    <= mdr_d;
        end
    end

    // Unified memory: bench load port during reset, sw stores otherwise.
    always_ff @(posedge clk) begin
        if (rst && load_we) begin
            mem_q[load_addr] <= load_data;
        end else if (mem_we) begin
            mem_q[aluout_q[2 +: AW]] <= b_q;
        end
    end

    // Register file write; x0 and out-of-range indices are dropped.
    always_ff @(posedge clk) begin
        if (rf_we && rd != 5'd0 && int'(rd) < NUM_REGS) begin
            regs_q[rd[RW-1:0]] <= rf_wdata;
        end
    end

endmodule

// File: tb/tb_multicycle_core.sv
// Scoreboard bench for multicycle_core: stimulus loads programs and queues the
// expected retire records; the monitor pops one per retire pulse and checks
// retire cycle, destination register and PC.
module tb_multicycle_core;

    localparam int XLEN = 32;
    localparam int MEM_WORDS = 1024;
    localparam int AW = 10;
    localparam logic [31:0] ILL = 32'hFFFF_FFFF;

    logic            clk, rst, load_we, retire, halted;
    logic [AW-1:0]   load_addr;
    logic [XLEN-1:0] load_data, dbg_rdata, pc;
    logic [4:0]      dbg_raddr;

    multicycle_core #(.XLEN(XLEN), .MEM_WORDS(MEM_WORDS), .NUM_REGS(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .load_we   (load_we),
        .load_addr (load_addr),
        .load_data (load_data),
        .dbg_raddr (dbg_raddr),
        .dbg_rdata (dbg_rdata),
        .pc        (pc),
        .retire    (retire),
        .halted    (halted)
    );

    typedef struct {
        int          cyc;
        logic [4:0]  rd;
        logic [31:0] val;
        logic [31:0] pc;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc;
    bit   mon_busy;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle number since reset release; cycle 1 is the first FETCH.
    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [2:0] f3,
                                          input logic [4:0] rd, input logic [4:0] rs1,
                                          input logic [4:0] rs2);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_lw(input logic [4:0] rd, input logic [4:0] rs1,
                                           input logic [11:0] imm);
        return {imm, rs1, 3'b010, rd, 7'b0000011};
    endfunction

    function automatic logic [31:0] enc_sw(input logic [4:0] rs2, input logic [4:0] rs1,
                                           input logic [11:0] imm);
        return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
    endfunction

    // Branch offset passed as bits [12:1]; bit 0 is always zero.
    function automatic logic [31:0] enc_beq(input logic [4:0] rs1, input logic [4:0] rs2,
                                            input logic [12:1] imm);
        return {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] enc_addi(input logic [4:0] rd, input logic [4:0] rs1,
                                             input logic [11:0] imm);
        return {imm, rs1, 3'b000, rd, 7'b0010011};
    endfunction

    function automatic exp_t mk(input int c, input logic [4:0] r, input logic [31:0] v,
                                input logic [31:0] p);
        exp_t e;
        e.cyc = c; e.rd = r; e.val = v; e.pc = p;
        return e;
    endfunction

    // Monitor: one scoreboard entry per retire pulse.
    initial begin
        exp_t e;
        dbg_raddr = 5'd0;
        mon_busy  = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst && retire === 1'b1) begin
                mon_busy = 1'b1;
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_retire: got retire at cycle %0d pc %h expected none",
                             cyc + 1, pc);
                end else begin
                    e = exp_q.pop_front();
                    check("retire_cycle", 32'(cyc + 1), 32'(e.cyc));
                    dbg_raddr = e.rd;
                    @(negedge clk);
                    check($sformatf("reg_x%0d", e.rd), dbg_rdata, e.val);
                    check("pc_after_retire", pc, e.pc);
                end
                mon_busy = 1'b0;
            end
        end
    end

    task automatic reset_start();
        rst     = 1'b1;
        load_we = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic load(input int idx, input logic [31:0] d);
        load_we   = 1'b1;
        load_addr = AW'(idx);
        load_data = d;
        @(negedge clk);
        load_we   = 1'b0;
    endtask

    task automatic wait_idle(input int max);
        int n = 0;
        while ((exp_q.size() != 0 || mon_busy) && n < max) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0 || mon_busy) begin
            n_tests++;
            n_fail++;
            $display("FAIL idle_timeout: got %0d pending expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; load_we = 1'b0; load_addr = '0; load_data = '0;
        reset_start();
        check("reset_pc", pc, 32'd0);
        check("reset_retire", 32'(retire), 32'd0);
        check("reset_halted", 32'(halted), 32'd0);

        // Load/add
        load(16, 32'd5);
        load(17, 32'd7);
        load(0, enc_lw(5'd1, 5'd0, 12'd64));
        load(1, enc_lw(5'd2, 5'd0, 12'd68));
        load(2, enc_r(7'h00, 3'b000, 5'd3, 5'd1, 5'd2));
        load(3, ILL);
        exp_q.push_back(mk(5, 5'd1, 32'd5, 32'd4));
        exp_q.push_back(mk(10, 5'd2, 32'd7, 32'd8));
        exp_q.push_back(mk(14, 5'd3, 32'd12, 32'd12));
        rst = 1'b0;
        wait_idle(100);
        repeat (4) @(negedge clk);
        check("t1_halted", 32'(halted), 32'd1);
        check("t1_pc_frozen", pc, 32'd16);

        // Store / read-back
        reset_start();
        load(0, enc_sw(5'd3, 5'd0, 12'd128));
        load(1, enc_lw(5'd4, 5'd0, 12'd128));
        load(2, ILL);
        exp_q.push_back(mk(4, 5'd0, 32'd0, 32'd4));
        exp_q.push_back(mk(9, 5'd4, 32'd12, 32'd8));
        rst = 1'b0;
        wait_idle(100);

        // Branch not taken (x5=12, x6=0)
        reset_start();
        load(0, enc_r(7'h00, 3'b000, 5'd5, 5'd1, 5'd2));
        load(1, enc_r(7'h00, 3'b000, 5'd6, 5'd0, 5'd0));
        load(2, enc_beq(5'd5, 5'd6, 12'hFFC));
        load(3, ILL);
        exp_q.push_back(mk(4, 5'd5, 32'd12, 32'd4));
        exp_q.push_back(mk(8, 5'd6, 32'd0, 32'd8));
        exp_q.push_back(mk(11, 5'd0, 32'd0, 32'd12));
        rst = 1'b0;
        wait_idle(100);

        // Branch taken back to 0; reset before the loop retires again
        reset_start();
        load(2, enc_beq(5'd0, 5'd0, 12'hFFC));
        exp_q.push_back(mk(4, 5'd5, 32'd12, 32'd4));
        exp_q.push_back(mk(8, 5'd6, 32'd0, 32'd8));
        exp_q.push_back(mk(11, 5'd0, 32'd0, 32'd0));
        rst = 1'b0;
        wait_idle(100);

        // x0 writes, slt, sub, and, or
        reset_start();
        load(40, 32'hFFFF_FFFF);
        load(41, 32'd1);
        load(0, enc_lw(5'd6, 5'd0, 12'd160));
        load(1, enc_lw(5'd7, 5'd0, 12'd164));
        load(2, enc_r(7'h00, 3'b000, 5'd0, 5'd1, 5'd2));
        load(3, enc_r(7'h00, 3'b010, 5'd5, 5'd6, 5'd7));
        load(4, enc_r(7'h20, 3'b000, 5'd8, 5'd7, 5'd6));
        load(5, enc_r(7'h00, 3'b111, 5'd9, 5'd6, 5'd7));
        load(6, enc_r(7'h00, 3'b110, 5'd10, 5'd1, 5'd2));
        load(7, enc_r(7'h00, 3'b010, 5'd11, 5'd7, 5'd6));
        load(8, ILL);
        exp_q.push_back(mk(5, 5'd6, 32'hFFFF_FFFF, 32'd4));
        exp_q.push_back(mk(10, 5'd7, 32'd1, 32'd8));
        exp_q.push_back(mk(14, 5'd0, 32'd0, 32'd12));
        exp_q.push_back(mk(18, 5'd5, 32'd1, 32'd16));
        exp_q.push_back(mk(22, 5'd8, 32'd2, 32'd20));
        exp_q.push_back(mk(26, 5'd9, 32'd1, 32'd24));
        exp_q.push_back(mk(30, 5'd10, 32'd7, 32'd28));
        exp_q.push_back(mk(34, 5'd11, 32'd0, 32'd32));
        rst = 1'b0;
        wait_idle(200);

        // Illegal opcode at PC 0
        reset_start();
        load(0, ILL);
        rst = 1'b0;
        @(negedge clk);
        check("ill_decode_not_halted", 32'(halted), 32'd0);
        @(negedge clk);
        check("ill_halted", 32'(halted), 32'd1);
        check("ill_pc", pc, 32'd4);
        repeat (5) @(negedge clk);
        check("ill_still_halted", 32'(halted), 32'd1);
        check("ill_pc_frozen", pc, 32'd4);
        rst = 1'b1;
        @(negedge clk);
        check("ill_reset_halted", 32'(halted), 32'd0);
        check("ill_reset_pc", pc, 32'd0);

        // Optional I-type
        reset_start();
        load(0, enc_addi(5'd1, 5'd0, 12'hFFD));
        load(1, ILL);
`ifdef MULTICYCLE_ITYPE_EN
        exp_q.push_back(mk(4, 5'd1, 32'hFFFF_FFFD, 32'd4));
        rst = 1'b0;
        wait_idle(100);
`else
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("itype_off_halted", 32'(halted), 32'd1);
        check("itype_off_pc", pc, 32'd4);
`endif

        // Reset mid-instruction, then rerun from PC 0
        reset_start();
        load(0, enc_lw(5'd12, 5'd0, 12'd64));
        load(1, ILL);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_pc", pc, 32'd0);
        check("midrst_retire", 32'(retire), 32'd0);
        check("midrst_halted", 32'(halted), 32'd0);
        exp_q.push_back(mk(5, 5'd12, 32'd5, 32'd4));
        rst = 1'b0;
        wait_idle(100);

        rst = 1'b1;
        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
